iter_alu: RTL and testbench
===========================

ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter WIDTH, 16, operand/result width in bits (>=4, power of two).
REQ-002 Parameter SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 pwr_en  input  1  power domain enable; low = block powered down.
REQ-006 iso_en  input  1  isolation enable; high = outputs clamped.
REQ-007 in_valid  input  1  operation request.
REQ-008 in_ready  output  1  block can accept a request.
REQ-009 a, b  input  WIDTH each  operands.
REQ-010 opcode  input  4  operation select.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  WIDTH  primary result (sum, logic, product low half, quotient).
REQ-014 result_ext  output  WIDTH  product high half for MUL, remainder for DIV, else 0.
REQ-015 err  output  1  divide-by-zero or illegal opcode for the held result.
REQ-016 busy  output  1  high whenever state != IDLE.

Function
REQ-017 States IDLE, MUL, DIV, DONE; in_ready = (state==IDLE) & pwr_en & ~iso_en.
REQ-018 Accept = in_valid & in_ready; a, b, opcode captured on accept; inputs ignored otherwise.
REQ-019 Opcodes 0-7: add, sub, and, or, xor, nor, a>>b[SHW-1:0], xnor; add/sub wrap modulo 2^WIDTH; result registered, DONE next cycle (out_valid 1 cycle after accept).
REQ-020 Opcode 8 MUL: unsigned shift-add, one bit per cycle, WIDTH cycles in MUL; {result_ext,result} = full 2*WIDTH product; out_valid WIDTH+1 cycles after accept.
REQ-021 Opcode 9 DIV: unsigned restoring division, WIDTH cycles in DIV; result = quotient, result_ext = remainder; out_valid WIDTH+1 cycles after accept.
REQ-022 DIV with b==0: skip DIV state, DONE next cycle with result = all ones, result_ext = a, err = 1.
REQ-023 Opcodes 10-15 (without macro, REQ-031): DONE next cycle, result = 0, result_ext = 0, err = 1.
REQ-024 DONE: out_valid = 1, result/result_ext/err held stable until out_ready; out_valid & out_ready -> IDLE next cycle; no new accept in that same cycle.
REQ-025 in_valid held while busy is not accepted and not lost by the producer's obligation; block never queues more than one operation.
REQ-026 pwr_en low or iso_en high in any state: next cycle state = IDLE, iteration counter and partial results cleared, in-flight or held result discarded.
REQ-027 iso_en high: out_valid, in_ready, busy, err, result, result_ext clamped to 0 combinationally in the same cycle.
REQ-028 pwr_en low with iso_en low: outputs reflect cleared registers (all 0) from next cycle.

Reset
REQ-029 rst_n low at a rising edge: state = IDLE, counter = 0, result = 0, result_ext = 0, err = 0, out_valid = 0; busy = 0.
REQ-030 Reset mid-MUL/DIV or in DONE aborts the operation with no out_valid pulse; reset dominates pwr_en/iso_en.

Configuration
REQ-031 Macro ITER_ALU_ROTATE_EN defined: opcode 10 = rotate-left a by b[SHW-1:0], opcode 11 = rotate-right, single-cycle, err = 0; opcodes 12-15 illegal.
REQ-032 Macro not defined: opcodes 10-15 illegal per REQ-023; no rotate logic synthesised.

Structure
REQ-033 Package iter_alu_pkg holds opcode enum (OP_ADD..OP_ROR), state enum, and opcode width constant.
REQ-034 Sub-module iter_alu_seq_core holds the shared shift-add/restoring-divide datapath and counter; top holds FSM, handshake, single-cycle ops, isolation clamp.

Verification (WIDTH=16)
REQ-035 a=0xFFFF, b=0x0001, op=0 accepted -> next cycle out_valid, result=0x0000, err=0.
REQ-036 a=0x1234, b=0x0100, op=8 -> out_valid exactly 17 cycles after accept, result_ext=0x0012, result=0x3400.
REQ-037 a=100, b=7, op=9 -> 17 cycles, result=14, result_ext=2; a=5, b=0, op=9 -> 1 cycle, result=0xFFFF, result_ext=5, err=1.
REQ-038 MUL in flight, iso_en pulsed at cycle 5 -> outputs 0 immediately, IDLE next cycle, no out_valid; next request completes correctly.
REQ-039 DONE with out_ready=0 for 10 cycles -> result stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-040 op=10, a=0x8001, b=1: with ITER_ALU_ROTATE_EN -> result=0x0003, err=0; without -> result=0, err=1.

Source files
------------

// File: rtl/iter_alu_pkg.sv
// iter_alu shared types: opcode and FSM state encodings.
// The rotate opcodes are only decoded when ITER_ALU_ROTATE_EN is defined.
package iter_alu_pkg;

    localparam int unsigned OPW = 4;

    typedef enum logic [OPW-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOR  = 4'd5,
        OP_SHR  = 4'd6,
        OP_XNOR = 4'd7,
        OP_MUL  = 4'd8,
        OP_DIV  = 4'd9,
        OP_ROL  = 4'd10,
        OP_ROR  = 4'd11
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/iter_alu_seq_core.sv
// Shared iterative datapath: unsigned shift-add multiply and restoring divide.
// {hi,lo} is the product register for MUL and {remainder,quotient} for DIV.
// hi_nxt_o/lo_nxt_o present the value the current step will write, so the
// controller can capture the final result on the last step edge.
module iter_alu_seq_core
    import iter_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             start_mul_i,
    input  logic             start_div_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] hi_nxt_o,
    output logic [WIDTH-1:0] lo_nxt_o
);

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;
    logic [SHW-1:0]   cnt_q;
    logic             div_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    // One iteration of the selected algorithm.
    always_comb begin
        sum     = {1'b0, hi_q} + {1'b0, b_q};
        r_sh    = {hi_q, lo_q[WIDTH-1]};
        diff    = r_sh[WIDTH-1:0] - b_q;
        step_hi = hi_q;
        step_lo = lo_q;
        if (div_q) begin
            if (r_sh >= {1'b0, b_q}) begin
                step_hi = diff;
                step_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = r_sh[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (lo_q[0]) begin
                {step_hi, step_lo} = {sum, lo_q[WIDTH-1:1]};
            end else begin
                {step_hi, step_lo} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
            end
        end
    end

    assign last_o   = step_i && (cnt_q == SHW'(WIDTH - 1));
    assign hi_nxt_o = step_hi;
    assign lo_nxt_o = step_lo;

    // Operand load, iteration and counter; clr_i discards partial state.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else if (start_mul_i || start_div_i) begin
            hi_q  <= '0;
            lo_q  <= a_i;
            b_q   <= b_i;
            cnt_q <= '0;
            div_q <= start_div_i;
        end else if (step_i) begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            cnt_q <= cnt_q + SHW'(1);
        end
    end

endmodule

// File: rtl/iter_alu.sv
// Iterative ALU top: FSM, valid/ready handshake, single-cycle ops and the
// isolation clamp. Define ITER_ALU_ROTATE_EN to add rotate-left/right on
// opcodes 10/11; otherwise those opcodes are reported as illegal.
module iter_alu
    import iter_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwr_en,
    input  logic             iso_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_ext,
    output logic             err,
    output logic             busy
);

    state_e           state_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_ext_q;
    logic             err_q;

    opcode_e          op;
    logic             accept;
    logic             flush;
    logic [WIDTH-1:0] sc_res;
    logic             sc_illegal;
    logic             core_last;
    logic [WIDTH-1:0] core_hi;
    logic [WIDTH-1:0] core_lo;
    logic             start_mul;
    logic             start_div;
    logic             core_step;

    assign op        = opcode_e'(opcode);
    assign in_ready  = (state_q == ST_IDLE) && pwr_en && !iso_en;
    assign accept    = in_valid && in_ready;
    assign flush     = !pwr_en || iso_en;
    assign start_mul = accept && (op == OP_MUL);
    assign start_div = accept && (op == OP_DIV) && (b != '0);
    assign core_step = (state_q == ST_MUL) || (state_q == ST_DIV);

`ifdef ITER_ALU_ROTATE_EN
    logic [SHW-1:0]   rot_amt;
    logic [WIDTH-1:0] rol_res;
    logic [WIDTH-1:0] ror_res;

    // Rotates; a shift by WIDTH yields zero, covering rot_amt == 0.
    always_comb begin
        rot_amt = b[SHW-1:0];
        rol_res = (a << rot_amt) | (a >> (WIDTH - 32'(rot_amt)));
        ror_res = (a >> rot_amt) | (a << (WIDTH - 32'(rot_amt)));
    end
`endif

    // Single-cycle result and illegal-opcode decode.
    always_comb begin
        sc_res     = '0;
        sc_illegal = 1'b0;
        case (op)
            OP_ADD:  sc_res = a + b;
            OP_SUB:  sc_res = a - b;
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_NOR:  sc_res = ~(a | b);
            OP_SHR:  sc_res = a >> b[SHW-1:0];
            OP_XNOR: sc_res = ~(a ^ b);
            OP_MUL:  sc_res = '0;
            OP_DIV:  sc_res = '0;
`ifdef ITER_ALU_ROTATE_EN
            OP_ROL:  sc_res = rol_res;
            OP_ROR:  sc_res = ror_res;
`endif
            default: sc_illegal = 1'b1;
        endcase
    end

    iter_alu_seq_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_seq_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (flush),
        .start_mul_i (start_mul),
        .start_div_i (start_div),
        .step_i      (core_step),
        .a_i         (a),
        .b_i         (b),
        .last_o      (core_last),
        .hi_nxt_o    (core_hi),
        .lo_nxt_o    (core_lo)
    );

    // Control FSM with registered result, extension and error.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state_q      <= ST_IDLE;
            result_q     <= '0;
            result_ext_q <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            err_q   <= 1'b0;
                            state_q <= ST_MUL;
                        end else if (op == OP_DIV) begin
                            if (b == '0) begin
                                result_q     <= '1;
                                result_ext_q <= a;
                                err_q        <= 1'b1;
                                state_q      <= ST_DONE;
                            end else begin
                                err_q   <= 1'b0;
                                state_q <= ST_DIV;
                            end
                        end else begin
                            result_q     <= sc_res;
                            result_ext_q <= '0;
                            err_q        <= sc_illegal;
                            state_q      <= ST_DONE;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (core_last) begin
                        result_q     <= core_lo;
                        result_ext_q <= core_hi;
                        err_q        <= 1'b0;
                        state_q      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Isolation clamps every output low in the same cycle.
    assign out_valid  = !iso_en && (state_q == ST_DONE);
    assign busy       = !iso_en && (state_q != ST_IDLE);
    assign err        = !iso_en && err_q;
    assign result     = iso_en ? '0 : result_q;
    assign result_ext = iso_en ? '0 : result_ext_q;

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu (WIDTH=16). Build with ITER_ALU_ROTATE_EN
// defined to exercise the rotate opcodes.
module tb_iter_alu;

    logic        clk;
    logic        rst_n;
    logic        pwr_en;
    logic        iso_en;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  opcode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [15:0] result_ext;
    logic        err;
    logic        busy;

    typedef struct {
        logic [15:0] res;
        logic [15:0] ext;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    iter_alu #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwr_en     (pwr_en),
        .iso_en     (iso_en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .opcode     (opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .result_ext (result_ext),
        .err        (err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic [3:0] op);
        exp_t        e;
        logic [31:0] p;
        logic [15:0] r;
        logic [3:0]  sh;
        e.res = 16'h0;
        e.ext = 16'h0;
        e.err = 1'b0;
        e.lat = 1;
        sh    = y[3:0];
        r     = x;
        p     = 32'h0;
        case (op)
            4'd0: e.res = x + y;
            4'd1: e.res = x - y;
            4'd2: e.res = x & y;
            4'd3: e.res = x | y;
            4'd4: e.res = x ^ y;
            4'd5: e.res = ~(x | y);
            4'd6: e.res = x >> sh;
            4'd7: e.res = ~(x ^ y);
            4'd8: begin
                p     = 32'(x) * 32'(y);
                e.res = p[15:0];
                e.ext = p[31:16];
                e.lat = 17;
            end
            4'd9: begin
                if (y == 16'h0) begin
                    e.res = 16'hFFFF;
                    e.ext = x;
                    e.err = 1'b1;
                end else begin
                    e.res = x / y;
                    e.ext = x % y;
                    e.lat = 17;
                end
            end
`ifdef ITER_ALU_ROTATE_EN
            4'd10: begin
                for (int i = 0; i < int'(sh); i++) r = {r[14:0], r[15]};
                e.res = r;
            end
            4'd11: begin
                for (int i = 0; i < int'(sh); i++) r = {r[0], r[15:1]};
                e.res = r;
            end
`endif
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // Called at a negedge; returns at the negedge one cycle after the accept edge.
    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic [3:0] op, input bit push);
        int t = 0;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        opcode   = op;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            if (push) sb_q.push_back(model(x, y, op));
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            a        = 16'($urandom);
            b        = 16'($urandom);
            opcode   = 4'($urandom);
        end
    endtask

    // Wait for the result, compare against the scoreboard head, hold, then release.
    task automatic collect(input int hold);
        int   lat = 1;
        exp_t e;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            check("done_timeout", 64'(out_valid), 64'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else if (sb_q.size() == 0) begin
            check("sb_empty", 64'(sb_q.size()), 64'd1);
        end else begin
            e = sb_q.pop_front();
            check("latency", 64'(lat), 64'(e.lat));
            check("result", 64'(result), 64'(e.res));
            check("result_ext", 64'(result_ext), 64'(e.ext));
            check("err", 64'(err), 64'(e.err));
            check("in_ready_done", 64'(in_ready), 64'd0);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_result", 64'({result_ext, result, err}), 64'({e.ext, e.res, e.err}));
                check("hold_in_ready", 64'(in_ready), 64'd0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("post_valid", 64'(out_valid), 64'd0);
            check("post_in_ready", 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        int seen;
        logic [15:0] rx;
        logic [15:0] ry;
        logic [3:0]  rop;

        rst_n     = 1'b0;
        pwr_en    = 1'b1;
        iso_en    = 1'b0;
        in_valid  = 1'b1;
        a         = 16'h1111;
        b         = 16'h2222;
        opcode    = 4'd0;
        out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_outputs", 64'({result_ext, result, err}), 64'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed cases
        drive(16'hFFFF, 16'h0001, 4'd0, 1'b1); collect(0);
        drive(16'h1234, 16'h0100, 4'd8, 1'b1); collect(0);
        drive(16'd100,  16'd7,    4'd9, 1'b1); collect(0);
        drive(16'd5,    16'd0,    4'd9, 1'b1); collect(0);
        drive(16'h8001, 16'h0001, 4'd10, 1'b1); collect(0);
        drive(16'h8001, 16'h0003, 4'd11, 1'b1); collect(0);
        drive(16'hABCD, 16'h1234, 4'd12, 1'b1); collect(0);
        drive(16'hF0F0, 16'h0014, 4'd6, 1'b1); collect(0);
        drive(16'hFFFF, 16'hFFFF, 4'd8, 1'b1); collect(0);
        drive(16'h0003, 16'hFFFF, 4'd9, 1'b1); collect(0);

        // Random mix
        for (int i = 0; i < 12; i++) begin
            rx  = 16'($urandom);
            ry  = 16'($urandom);
            rop = 4'($urandom_range(0, 15));
            drive(rx, ry, rop, 1'b1);
            collect(0);
        end

        // Result held under backpressure
        drive(16'hBEEF, 16'h1111, 4'd1, 1'b1); collect(10);

        // Request held during MUL waits, then is taken after release
        drive(16'h0007, 16'h0009, 4'd8, 1'b1);
        in_valid = 1'b1; a = 16'hAAAA; b = 16'h0000; opcode = 4'd9;
        check("busy_in_ready", 64'(in_ready), 64'd0);
        collect(0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        sb_q.push_back(model(16'hAAAA, 16'h0000, 4'd9));
        collect(0);

        // Isolation during MUL
        drive(16'h1234, 16'h5678, 4'd8, 1'b0);
        repeat (4) @(negedge clk);
        check("iso_pre_busy", 64'(busy), 64'd1);
        iso_en = 1'b1;
        #1;
        check("iso_clamp", 64'({out_valid, in_ready, busy, err, result, result_ext}), 64'd0);
        @(negedge clk);
        iso_en = 1'b0;
        #1;
        check("iso_idle_busy", 64'(busy), 64'd0);
        check("iso_idle_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("iso_no_valid", 64'(seen), 64'd0);
        drive(16'h00FF, 16'h0101, 4'd8, 1'b1); collect(0);

        // Power-down while holding an error result clears it
        drive(16'h5A5A, 16'h0000, 4'd9, 1'b0);
        check("pwr_pre_valid", 64'(out_valid), 64'd1);
        pwr_en = 1'b0;
        #1;
        check("pwr_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("pwr_cleared", 64'({out_valid, busy, err, result, result_ext}), 64'd0);
        pwr_en = 1'b1;
        @(negedge clk);
        check("pwr_back_in_ready", 64'(in_ready), 64'd1);

        // Reset mid-DIV aborts without a result
        drive(16'd1000, 16'd3, 4'd9, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_no_valid", 64'(seen), 64'd0);
        drive(16'd1000, 16'd3, 4'd9, 1'b1); collect(0);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
